// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default field widths and the
// normalizer state encoding.
package fp_pkg;

    localparam int SIZE_EXP = 8;
    localparam int SIZE_MAN = 24;

    localparam logic [SIZE_EXP-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

endpackage

// File: rtl/exp_normalize_seq_if.sv
// Handshake bundle between the mantissa adder, the normalizer and the
// rounding stage. The slave modport is the normalizer's view.
interface exp_normalize_seq_if #(
    parameter int SIZE_EXP = fp_pkg::SIZE_EXP,
    parameter int SIZE_MAN = fp_pkg::SIZE_MAN
);

    logic                i_valid;
    logic                o_ready;
    logic [SIZE_EXP-1:0] i_exp;
    logic [SIZE_MAN:0]   i_man;

    logic                o_valid;
    logic                i_ready;
    logic [SIZE_EXP-1:0] o_exp;
    logic [SIZE_MAN-1:0] o_man;
    logic                o_overflow;
    logic                o_underflow;
    logic                o_zero;

    modport master (
        output i_valid, i_exp, i_man, i_ready,
        input  o_ready, o_valid, o_exp, o_man, o_overflow, o_underflow, o_zero
    );

    modport slave (
        input  i_valid, i_exp, i_man, i_ready,
        output o_ready, o_valid, o_exp, o_man, o_overflow, o_underflow, o_zero
    );

endinterface

// File: rtl/EXP_norm_step.sv
// One combinational normalization step: either the hidden bit is already set,
// the exponent has bottomed out (denormal), or shift left by one.
module EXP_norm_step #(
    parameter int SIZE_EXP = fp_pkg::SIZE_EXP,
    parameter int SIZE_MAN = fp_pkg::SIZE_MAN
) (
    input  logic [SIZE_EXP-1:0] exp_i,
    input  logic [SIZE_MAN:0]   man_i,
    output logic [SIZE_EXP-1:0] exp_o,
    output logic [SIZE_MAN:0]   man_o,
    output logic                done_o,
    output logic                underflow_o
);

    localparam logic [SIZE_EXP-1:0] EXP_ONE = {{(SIZE_EXP-1){1'b0}}, 1'b1};

    always_comb begin
        exp_o       = exp_i;
        man_o       = man_i;
        done_o      = 1'b0;
        underflow_o = 1'b0;
        if (man_i[SIZE_MAN-1]) begin
            done_o = 1'b1;
            // A denormal sum that reached the hidden bit is now a normal number.
            if (exp_i == '0) begin
                exp_o = EXP_ONE;
            end
        end else if (exp_i <= EXP_ONE) begin
            done_o      = 1'b1;
            underflow_o = 1'b1;
            exp_o       = '0;
        end else begin
            man_o = man_i << 1;
            exp_o = exp_i - EXP_ONE;
        end
    end

endmodule

// File: rtl/exp_normalize_seq.sv
// Sequential post-add normalizer: handles carry-out in one cycle, otherwise
// removes leading zeros one bit per cycle, flagging overflow/underflow/zero.
module exp_normalize_seq
    import fp_pkg::*;
#(
    parameter int SIZE_EXP = fp_pkg::SIZE_EXP,
    parameter int SIZE_MAN = fp_pkg::SIZE_MAN
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    exp_normalize_seq_if.slave bus
);

    localparam logic [SIZE_EXP-1:0] EXP_ONES = {SIZE_EXP{1'b1}};
    localparam logic [SIZE_EXP-1:0] EXP_ONE  = {{(SIZE_EXP-1){1'b0}}, 1'b1};

    norm_state_t         state_q;
    logic [SIZE_EXP-1:0] exp_q;
    logic [SIZE_MAN:0]   man_q;
    logic                ready_q;
    logic                valid_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                zero_q;

    logic [SIZE_EXP-1:0] step_exp_d;
    logic [SIZE_MAN:0]   step_man_d;
    logic                step_done_d;
    logic                step_underflow_d;

    EXP_norm_step #(
        .SIZE_EXP (SIZE_EXP),
        .SIZE_MAN (SIZE_MAN)
    ) u_step (
        .exp_i       (exp_q),
        .man_i       (man_q),
        .exp_o       (step_exp_d),
        .man_o       (step_man_d),
        .done_o      (step_done_d),
        .underflow_o (step_underflow_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            man_q       <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        ready_q <= 1'b0;
                        if (bus.i_man == '0) begin
                            exp_q   <= '0;
                            man_q   <= '0;
                            zero_q  <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else if (bus.i_man[SIZE_MAN]) begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                            // Saturate at all-ones: an exponent already at the top cannot wrap.
                            if (bus.i_exp >= EXP_ONES - EXP_ONE) begin
                                exp_q      <= EXP_ONES;
                                man_q      <= '0;
                                overflow_q <= 1'b1;
                            end else begin
                                exp_q <= bus.i_exp + EXP_ONE;
                                man_q <= bus.i_man >> 1;
                            end
                        end else begin
                            exp_q   <= bus.i_exp;
                            man_q   <= bus.i_man;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    exp_q <= step_exp_d;
                    man_q <= step_man_d;
                    if (step_done_d) begin
                        underflow_q <= step_underflow_d;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q     <= 1'b0;
                        ready_q     <= 1'b1;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        zero_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_exp       = exp_q;
    assign bus.o_man       = man_q[SIZE_MAN-1:0];
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
    assign bus.o_zero      = zero_q;

endmodule

// File: tb/tb_exp_normalize_seq.sv
// Self-checking bench for exp_normalize_seq: directed cases, backpressure,
// mid-operation reset and randomized operands against a reference model.
module tb_exp_normalize_seq;

    logic i_clk;
    logic i_rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_normalize_seq_if #(.SIZE_EXP(8), .SIZE_MAN(24)) bus ();

    exp_normalize_seq #(.SIZE_EXP(8), .SIZE_MAN(24)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  e;
        logic [23:0] m;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          lat;
    } res_t;

    // Expected result from the arithmetic rules: lat = clock edges after the
    // accepting edge until o_valid is seen.
    function automatic res_t model(input logic [7:0] e, input logic [24:0] m);
        res_t r;
        int   k;
        int   s;
        int   ei;
        ei     = int'(e);
        r.ovf  = 1'b0;
        r.unf  = 1'b0;
        r.zero = 1'b0;
        r.lat  = 0;
        r.e    = 8'h00;
        r.m    = 24'h0;
        if (m == 25'h0) begin
            r.zero = 1'b1;
        end else if (m[24]) begin
            if (ei + 1 >= 255) begin
                r.ovf = 1'b1;
                r.e   = 8'hFF;
            end else begin
                r.e = 8'(ei + 1);
                r.m = m[24:1];
            end
        end else begin
            k = 0;
            while (k < 23 && m[23-k] == 1'b0) k++;
            if (k == 0) begin
                r.e   = (ei == 0) ? 8'd1 : e;
                r.m   = m[23:0];
                r.lat = 1;
            end else if (k < ei) begin
                r.e   = 8'(ei - k);
                r.m   = 24'(m << k);
                r.lat = k + 1;
            end else begin
                s     = (ei == 0) ? 0 : ei - 1;
                r.unf = 1'b1;
                r.m   = 24'(m << s);
                r.lat = s + 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [7:0] e, input logic [24:0] m, input int hold);
        res_t r;
        int   cyc;
        logic [7:0]  e_hold;
        logic [23:0] m_hold;
        r = model(e, m);
        check("ready_idle", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_exp   = e;
        bus.i_man   = m;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_ready = (hold == 0);
        check("ready_busy", 32'(bus.o_ready), 32'd0);
        cyc = 0;
        while (!bus.o_valid && cyc <= 40) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(r.lat));
        check("o_exp", 32'(bus.o_exp), 32'(r.e));
        check("o_man", 32'(bus.o_man), 32'(r.m));
        check("flags", 32'({bus.o_overflow, bus.o_underflow, bus.o_zero}),
              32'({r.ovf, r.unf, r.zero}));
        e_hold = bus.o_exp;
        m_hold = bus.o_man;
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            check("bp_valid", 32'(bus.o_valid), 32'd1);
            check("bp_ready", 32'(bus.o_ready), 32'd0);
            check("bp_exp", 32'(bus.o_exp), 32'(e_hold));
            check("bp_man", 32'(bus.o_man), 32'(m_hold));
        end
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("hs_valid", 32'(bus.o_valid), 32'd0);
        check("hs_ready", 32'(bus.o_ready), 32'd1);
        check("hs_flags", 32'({bus.o_overflow, bus.o_underflow, bus.o_zero}), 32'd0);
        $display("op exp=%h man=%h -> exp=%h man=%h ovf=%0b unf=%0b zero=%0b lat=%0d",
                 e, m, e_hold, m_hold, r.ovf, r.unf, r.zero, cyc);
    endtask

    initial begin
        logic [7:0]  re;
        logic [24:0] rm;
        int          sel;
        int          hold;

        i_rst_n     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_exp   = 8'h00;
        bus.i_man   = 25'h0;
        bus.i_ready = 1'b1;
        #12;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_exp", 32'(bus.o_exp), 32'd0);
        check("rst_man", 32'(bus.o_man), 32'd0);
        check("rst_flags", 32'({bus.o_overflow, bus.o_underflow, bus.o_zero}), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed cases from the test plan
        run_op(8'h80, 25'h1000000, 0);
        run_op(8'h80, 25'h0000001, 0);
        run_op(8'h03, 25'h0100000, 0);
        run_op(8'hFE, 25'h1800000, 0);
        run_op(8'h45, 25'h0000000, 0);
        run_op(8'hFF, 25'h1234567, 0);
        run_op(8'h00, 25'h0800000, 0);
        run_op(8'h00, 25'h0012345, 0);
        run_op(8'h02, 25'h0400000, 0);
        run_op(8'h10, 25'h0C00000, 0);

        // Backpressure in DONE
        run_op(8'h20, 25'h0003000, 5);

        // Reset while shifting discards the operation
        bus.i_valid = 1'b1;
        bus.i_exp   = 8'h80;
        bus.i_man   = 25'h0000001;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_exp", 32'(bus.o_exp), 32'd0);
        check("mid_rst_man", 32'(bus.o_man), 32'd0);
        check("mid_rst_flags", 32'({bus.o_overflow, bus.o_underflow, bus.o_zero}), 32'd0);
        $display("reset asserted mid-shift");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run_op(8'h80, 25'h0000100, 0);

        // Randomized operands
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       re = 8'($urandom_range(0, 5));
                1:       re = 8'($urandom_range(250, 255));
                default: re = 8'($urandom);
            endcase
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                rm = 25'h0;
            end else if (sel <= 2) begin
                rm = {1'b1, 24'($urandom)};
            end else begin
                rm = {2'b01, 23'($urandom)};
                rm = rm >> $urandom_range(0, 23);
            end
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(re, rm, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
